// File: rtl/sc_upcount_pulsegen_if.sv
// rtl/sc_upcount_pulsegen_if.sv - pushbutton/pulse signal bundle for sc_upcount_pulsegen
//
// Purpose:
//   Groups the button-side inputs and the conditioned pulse outputs of
//   sc_upcount_pulsegen so that producer and consumer share one port.
// Signals:
//   SC_UPCOUNTPULSE_button_InLow    raw asynchronous pushbutton, 0 = pressed
//   SC_UPCOUNTPULSE_repeat_InHigh   1 = auto-repeat enabled, sampled every cycle
//   SC_UPCOUNTPULSE_upcount_OutLow  registered pulse, 0 for exactly one cycle per event
//   SC_UPCOUNTPULSE_held_OutHigh    1 while a debounced press is active
// Modports:
//   master  drives button/repeat, observes upcount/held (board or bench side)
//   slave   the pulse generator itself

interface sc_upcount_pulsegen_if;
  logic SC_UPCOUNTPULSE_button_InLow;
  logic SC_UPCOUNTPULSE_repeat_InHigh;
  logic SC_UPCOUNTPULSE_upcount_OutLow;
  logic SC_UPCOUNTPULSE_held_OutHigh;

  modport master (
    output SC_UPCOUNTPULSE_button_InLow,
    output SC_UPCOUNTPULSE_repeat_InHigh,
    input  SC_UPCOUNTPULSE_upcount_OutLow,
    input  SC_UPCOUNTPULSE_held_OutHigh
  );

  modport slave (
    input  SC_UPCOUNTPULSE_button_InLow,
    input  SC_UPCOUNTPULSE_repeat_InHigh,
    output SC_UPCOUNTPULSE_upcount_OutLow,
    output SC_UPCOUNTPULSE_held_OutHigh
  );
endinterface

// File: rtl/sc_upcount_pulsegen.sv
// rtl/sc_upcount_pulsegen.sv - pushbutton debouncer and auto-repeat upcount pulse generator
//
// Purpose:
//   Turns a raw active-low pushbutton into clean single-cycle active-low
//   upcount pulses: 2-FF synchronizer, debounce FSM, optional auto-repeat
//   while the button stays held. One pulse equals one counter increment.
// Ports:
//   SC_UPCOUNTPULSE_CLOCK_50     in  system clock, all logic on its rising edge
//   SC_UPCOUNTPULSE_RESET_InLow  in  synchronous active-low reset
//   pulse_bus (slave modport):
//     SC_UPCOUNTPULSE_button_InLow    in  raw pushbutton, 0 = pressed
//     SC_UPCOUNTPULSE_repeat_InHigh   in  auto-repeat enable
//     SC_UPCOUNTPULSE_upcount_OutLow  out registered one-cycle low pulse
//     SC_UPCOUNTPULSE_held_OutHigh    out debounced press active
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles to accept a press or release (>=2)
//   REPEAT_DELAY     cycles from accepted press to first repeat pulse (>=2)
//   REPEAT_PERIOD    cycles between later repeat pulses (>=2)
//   CNT_WIDTH        timer width, must hold max(above)-1

module sc_upcount_pulsegen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_WIDTH       = 25
) (
  input  logic                  SC_UPCOUNTPULSE_CLOCK_50,
  input  logic                  SC_UPCOUNTPULSE_RESET_InLow,
  sc_upcount_pulsegen_if.slave  pulse_bus
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD_DELAY  = 3'd2,
    ST_HELD_REPEAT = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } state_t;

  // Terminal timer values; each compare either leaves the state or reloads
  // the timer, so the timer can never wrap.
  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LAST  = CNT_WIDTH'(REPEAT_PERIOD - 1);

  logic                 sync_meta;
  logic                 sync_q;
  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] timer_q;
  logic [CNT_WIDTH-1:0] timer_d;
  logic                 pulse_d;
  logic                 held_d;
  logic                 upcount_q;
  logic                 held_q;

  // Synchronizer resets to "released" so a button held through reset is
  // seen as a fresh press once reset lifts.
  always_ff @(posedge SC_UPCOUNTPULSE_CLOCK_50) begin
    if (!SC_UPCOUNTPULSE_RESET_InLow) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= pulse_bus.SC_UPCOUNTPULSE_button_InLow;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge SC_UPCOUNTPULSE_CLOCK_50) begin
    if (!SC_UPCOUNTPULSE_RESET_InLow) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      upcount_q <= 1'b1;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      upcount_q <= ~pulse_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!sync_q) begin
          state_d = ST_DEB_PRESS;
        end
      end

      ST_DEB_PRESS: begin
        if (sync_q) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = ST_HELD_DELAY;
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end

      ST_HELD_DELAY: begin
        if (sync_q) begin
          state_d = ST_DEB_RELEASE;
          timer_d = '0;
        end else if (!pulse_bus.SC_UPCOUNTPULSE_repeat_InHigh) begin
          // Repeat disabled: the delay restarts in full once re-enabled.
          timer_d = '0;
        end else if (timer_q == RD_LAST) begin
          state_d = ST_HELD_REPEAT;
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end

      ST_HELD_REPEAT: begin
        if (sync_q) begin
          state_d = ST_DEB_RELEASE;
          timer_d = '0;
        end else if (!pulse_bus.SC_UPCOUNTPULSE_repeat_InHigh) begin
          state_d = ST_HELD_DELAY;
          timer_d = '0;
        end else if (timer_q == RP_LAST) begin
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end

      ST_DEB_RELEASE: begin
        if (!sync_q) begin
          // Release glitch: still pressed, but the repeat delay starts over.
          state_d = ST_HELD_DELAY;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    held_d = (state_d == ST_HELD_DELAY) ||
             (state_d == ST_HELD_REPEAT) ||
             (state_d == ST_DEB_RELEASE);
  end

  assign pulse_bus.SC_UPCOUNTPULSE_upcount_OutLow = upcount_q;
  assign pulse_bus.SC_UPCOUNTPULSE_held_OutHigh   = held_q;

endmodule

// File: tb/tb_sc_upcount_pulsegen.sv
// tb/tb_sc_upcount_pulsegen.sv - self-checking bench for sc_upcount_pulsegen

module tb_sc_upcount_pulsegen;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_upcount_pulsegen_if bus ();

  sc_upcount_pulsegen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_WIDTH      (5)
  ) dut (
    .SC_UPCOUNTPULSE_CLOCK_50   (clk),
    .SC_UPCOUNTPULSE_RESET_InLow(rst_n),
    .pulse_bus                  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: debounce as run-length of consecutive synchronized
  // samples opposing the debounced level; repeat as a count of consecutive
  // enabled held cycles with pulses at RD, RD+RP, RD+2*RP, ...
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_pressed = 1'b0;
  int   m_run = 0, m_en = 0;
  logic exp_up = 1'b1, exp_held = 1'b0, model_valid = 1'b0;

  always @(posedge clk) begin
    logic sync_now, pulse;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0; m_run = 0; m_en = 0;
      exp_up = 1'b1; exp_held = 1'b0; model_valid = 1'b1;
    end else begin
      sync_now = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.SC_UPCOUNTPULSE_button_InLow;
      pulse = 1'b0;
      if (!m_pressed) begin
        m_run = (sync_now == 1'b0) ? m_run + 1 : 0;
        if (m_run == DEB + 1) begin
          m_pressed = 1'b1; m_run = 0; m_en = 0; pulse = 1'b1;
        end
      end else if (sync_now == 1'b1) begin
        m_run++; m_en = 0;
        if (m_run == DEB + 1) begin
          m_pressed = 1'b0; m_run = 0;
        end
      end else if (m_run != 0) begin
        m_run = 0; m_en = 0;
      end else if (!bus.SC_UPCOUNTPULSE_repeat_InHigh) begin
        m_en = 0;
      end else begin
        m_en++;
        if (m_en >= RD && ((m_en - RD) % RP) == 0) pulse = 1'b1;
      end
      exp_up   = ~pulse;
      exp_held = m_pressed;
    end
  end

  logic prev_up = 1'b1;
  always @(negedge clk) begin
    if (model_valid) begin
      check("upcount_vs_model", 32'(bus.SC_UPCOUNTPULSE_upcount_OutLow), 32'(exp_up));
      check("held_vs_model", 32'(bus.SC_UPCOUNTPULSE_held_OutHigh), 32'(exp_held));
      if (bus.SC_UPCOUNTPULSE_upcount_OutLow === 1'b0)
        check("no_adjacent_pulses", 32'(prev_up), 32'd1);
      prev_up = bus.SC_UPCOUNTPULSE_upcount_OutLow;
    end
  end

  int   edge_idx = 0;
  int   pulses[$];
  logic held_hist[$];

  task automatic start_window();
    pulses.delete();
    held_hist.delete();
    edge_idx = 0;
  endtask

  task automatic step(input logic b);
    bus.SC_UPCOUNTPULSE_button_InLow = b;
    @(posedge clk);
    @(negedge clk);
    if (bus.SC_UPCOUNTPULSE_upcount_OutLow === 1'b0) pulses.push_back(edge_idx);
    held_hist.push_back(bus.SC_UPCOUNTPULSE_held_OutHigh);
    edge_idx++;
  endtask

  task automatic check_pulse_list(input string name, input int lim, input int exp_q[$]);
    int got[$];
    foreach (pulses[i]) if (pulses[i] < lim) got.push_back(pulses[i]);
    check($sformatf("%s_count", name), 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_edge%0d", name, i), (i < got.size()) ? 32'(got[i]) : 32'hffffffff, 32'(exp_q[i]));
  endtask

  task automatic check_held_at(input string name, input int e, input logic exp);
    check(name, (e < held_hist.size()) ? 32'(held_hist[e]) : 32'hffffffff, 32'(exp));
  endtask

  initial begin
    int q[$];
    logic bounce[7];
    bounce = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.SC_UPCOUNTPULSE_button_InLow  = 1'b0;
    bus.SC_UPCOUNTPULSE_repeat_InHigh = 1'b0;

    // 1: reset held with button pressed
    start_window();
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("reset_up", 32'(bus.SC_UPCOUNTPULSE_upcount_OutLow), 32'd1);
      check("reset_held", 32'(bus.SC_UPCOUNTPULSE_held_OutHigh), 32'd0);
    end
    rst_n = 1'b1;

    // 2: clean press, no repeat, then release
    start_window();
    for (int i = 0; i < 20; i++) step(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1);
    q = '{6};
    check_pulse_list("t2_pulses", 1000, q);
    check_held_at("t2_held_e5", 5, 1'b0);
    check_held_at("t2_held_e6", 6, 1'b1);
    check_held_at("t2_held_e25", 25, 1'b1);
    check_held_at("t2_held_e26", 26, 1'b0);

    // 3: bouncing press
    start_window();
    for (int i = 0; i < 7; i++) step(bounce[i]);
    for (int i = 0; i < 13; i++) step(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1);
    q = '{13};
    check_pulse_list("t3_pulses", 1000, q);
    check_held_at("t3_held_e12", 12, 1'b0);
    check_held_at("t3_held_e13", 13, 1'b1);

    // 4: auto-repeat
    bus.SC_UPCOUNTPULSE_repeat_InHigh = 1'b1;
    start_window();
    for (int i = 0; i < 30; i++) step(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1);
    q = '{6, 16, 19, 22, 25, 28};
    check_pulse_list("t4_pulses", 30, q);
    check_held_at("t4_held_end", 39, 1'b0);

    // 5: release glitch
    bus.SC_UPCOUNTPULSE_repeat_InHigh = 1'b0;
    start_window();
    for (int i = 0; i < 20; i++) step(1'b0);
    step(1'b1); step(1'b1); step(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1);
    q = '{6};
    check_pulse_list("t5_pulses", 1000, q);
    check_held_at("t5_held_e24", 24, 1'b1);
    check_held_at("t5_held_e28", 28, 1'b1);
    check_held_at("t5_held_e29", 29, 1'b0);

    // 6: reset during auto-repeat with the button held
    bus.SC_UPCOUNTPULSE_repeat_InHigh = 1'b1;
    start_window();
    for (int i = 0; i < 18; i++) step(1'b0);
    q = '{6, 16};
    check_pulse_list("t6_pre_pulses", 1000, q);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("t6_reset_up", 32'(bus.SC_UPCOUNTPULSE_upcount_OutLow), 32'd1);
      check("t6_reset_held", 32'(bus.SC_UPCOUNTPULSE_held_OutHigh), 32'd0);
    end
    rst_n = 1'b1;
    start_window();
    for (int i = 0; i < 11; i++) step(1'b0);
    q = '{6};
    check_pulse_list("t6_post_pulses", 1000, q);
    bus.SC_UPCOUNTPULSE_repeat_InHigh = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1);
    check("t6_final_held", 32'(bus.SC_UPCOUNTPULSE_held_OutHigh), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
